// File: rtl/vadd_seq_pkg.sv
// Package: fp16 constants and the sequencer FSM encoding shared by the vadd_seq slice.
// Also provides the element-count clamp used when a new operation is accepted.
package vadd_seq_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_INF  = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    // Requests longer than the vector register simply process the whole register.
    function automatic int clampLen(input int len, input int vlen);
        return (len > vlen) ? vlen : len;
    endfunction

endpackage

// File: rtl/vadd_seq_if.sv
// Interface: operand, adder and result bundle between vadd_seq (slave) and its environment (master).
// The environment owns the request inputs and the external adder's Sum/Overflow.
interface vadd_seq_if
    import vadd_seq_pkg::*;
#(
    parameter int VLEN  = 16,
    parameter int LEN_W = 5
);

    logic                     Start;
    logic [LEN_W-1:0]         Len;
    logic [VLEN*FP16_W-1:0]   VecA;
    logic [VLEN*FP16_W-1:0]   VecB;
    logic [FP16_W-1:0]        AddA;
    logic [FP16_W-1:0]        AddB;
    logic [FP16_W-1:0]        AddSum;
    logic                     AddOvf;
    logic                     Busy;
    logic                     Done;
    logic [VLEN*FP16_W-1:0]   Result;
    logic                     OvfFlag;
    logic [LEN_W-1:0]         FirstOvfIdx;

    modport master (
        output Start, Len, VecA, VecB, AddSum, AddOvf,
        input  AddA, AddB, Busy, Done, Result, OvfFlag, FirstOvfIdx
    );

    modport slave (
        input  Start, Len, VecA, VecB, AddSum, AddOvf,
        output AddA, AddB, Busy, Done, Result, OvfFlag, FirstOvfIdx
    );

endinterface

// File: rtl/vadd_tag_pipe.sv
// Module: vadd_tag_pipe -- {valid, index} delay line that tracks which element each adder result belongs to.
// Depth matches the adder latency plus the issue register, so the output lines up with AddSum.
module vadd_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_empty
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_idx[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_idx[k]   <= r_idx[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];
    assign o_empty = ~|r_valid;

endmodule

// File: rtl/vadd_seq.sv
// Module: vadd_seq -- issues fp16 element pairs to an external pipelined adder and gathers the sums.
// Optional feature: define VADD_OVF_IDX_EN to report the first overflowing element index on FirstOvfIdx.
module vadd_seq
    import vadd_seq_pkg::*;
#(
    parameter int VLEN    = 16,
    parameter int ADD_LAT = 1,
    parameter int LEN_W   = 5
) (
    input  logic      Clk2,
    input  logic      Rst_n,
    vadd_seq_if.slave bus
);

    localparam int IDX_W = $clog2(VLEN);
    localparam int VEC_W = VLEN * FP16_W;

    seqState_t         r_state;
    logic [VEC_W-1:0]  r_vecA;
    logic [VEC_W-1:0]  r_vecB;
    logic [VEC_W-1:0]  r_result;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issueCnt;
    logic [FP16_W-1:0] r_addA;
    logic [FP16_W-1:0] r_addB;
    logic              r_busy;
    logic              r_done;
    logic              r_ovfFlag;
`ifdef VADD_OVF_IDX_EN
    logic [LEN_W-1:0]  r_firstOvfIdx;
`endif

    logic [LEN_W-1:0]  w_startLen;
    logic              w_issueLast;
    logic [IDX_W-1:0]  w_issueIdx;
    logic [FP16_W-1:0] w_elemA;
    logic [FP16_W-1:0] w_elemB;
    logic              w_tagInValid;
    logic [IDX_W-1:0]  w_tagInIdx;
    logic              w_tagOutValid;
    logic [IDX_W-1:0]  w_tagOutIdx;
    logic              w_pipeEmpty;

    assign w_startLen   = LEN_W'(clampLen(int'(bus.Len), VLEN));
    assign w_issueLast  = (r_issueCnt == r_len);
    assign w_issueIdx   = r_issueCnt[IDX_W-1:0];
    assign w_elemA      = r_vecA[FP16_W*int'(w_issueIdx) +: FP16_W];
    assign w_elemB      = r_vecB[FP16_W*int'(w_issueIdx) +: FP16_W];

    // A tag enters the pipe on every edge that places a real element on AddA/AddB.
    assign w_tagInValid = ((r_state == IDLE) && bus.Start && (w_startLen != '0)) ||
                          ((r_state == ISSUE) && !w_issueLast);
    assign w_tagInIdx   = (r_state == ISSUE) ? w_issueIdx : '0;

    vadd_tag_pipe #(
        .DEPTH (ADD_LAT + 1),
        .IDX_W (IDX_W)
    ) u_tagPipe (
        .clk     (Clk2),
        .rst_n   (Rst_n),
        .i_valid (w_tagInValid),
        .i_idx   (w_tagInIdx),
        .o_valid (w_tagOutValid),
        .o_idx   (w_tagOutIdx),
        .o_empty (w_pipeEmpty)
    );

    always_ff @(posedge Clk2 or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= IDLE;
            r_vecA     <= '0;
            r_vecB     <= '0;
            r_result   <= '0;
            r_len      <= '0;
            r_issueCnt <= '0;
            r_addA     <= FP16_ZERO;
            r_addB     <= FP16_ZERO;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovfFlag  <= 1'b0;
`ifdef VADD_OVF_IDX_EN
            r_firstOvfIdx <= '0;
`endif
        end else begin
            if (w_tagOutValid) begin
                r_result[FP16_W*int'(w_tagOutIdx) +: FP16_W] <= bus.AddSum;
                if (bus.AddOvf) begin
                    r_ovfFlag <= 1'b1;
                end
`ifdef VADD_OVF_IDX_EN
                if (bus.AddOvf && !r_ovfFlag) begin
                    r_firstOvfIdx <= LEN_W'(w_tagOutIdx);
                end
`endif
            end

            case (r_state)
                IDLE: begin
                    if (bus.Start) begin
                        r_vecA    <= bus.VecA;
                        r_vecB    <= bus.VecB;
                        r_len     <= w_startLen;
                        r_result  <= '0;
                        r_ovfFlag <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef VADD_OVF_IDX_EN
                        r_firstOvfIdx <= '0;
`endif
                        if (w_startLen != '0) begin
                            r_addA     <= bus.VecA[FP16_W-1:0];
                            r_addB     <= bus.VecB[FP16_W-1:0];
                            r_issueCnt <= LEN_W'(1);
                            r_state    <= ISSUE;
                        end else begin
                            r_state    <= DONE;
                        end
                    end
                end

                ISSUE: begin
                    if (w_issueLast) begin
                        r_addA  <= FP16_ZERO;
                        r_addB  <= FP16_ZERO;
                        r_state <= DRAIN;
                    end else begin
                        r_addA     <= w_elemA;
                        r_addB     <= w_elemB;
                        r_issueCnt <= r_issueCnt + LEN_W'(1);
                    end
                end

                DRAIN: begin
                    if (w_pipeEmpty) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef VADD_OVF_IDX_EN
                        if (!r_ovfFlag) begin
                            r_firstOvfIdx <= LEN_W'(VLEN);
                        end
`endif
                    end
                end

                // A zero-length request arrives here with Done still low and raises it one edge later.
                DONE: begin
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef VADD_OVF_IDX_EN
                        if (!r_ovfFlag) begin
                            r_firstOvfIdx <= LEN_W'(VLEN);
                        end
`endif
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.AddA    = r_addA;
    assign bus.AddB    = r_addB;
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Result  = r_result;
    assign bus.OvfFlag = r_ovfFlag;
`ifdef VADD_OVF_IDX_EN
    assign bus.FirstOvfIdx = r_firstOvfIdx;
`else
    assign bus.FirstOvfIdx = '0;
`endif

endmodule
